// File: rtl/ild_sequencer.sv
// Sequencer for the LD (nn),HL / LD HL,(nn) / LD (nn),A / LD A,(nn) family:
// fetches the two immediate bytes, then performs one or two memory transfers.
//
// state    | meaning
// IDLE     | waiting for a one-hot start request
// FETCH_LO | reading nn[7:0] from PCcap
// FETCH_HI | reading nn[15:8] from PCcap+1
// XFER0    | first data transfer at nn
// XFER1    | second data transfer at nn+1 (16-bit kinds only)
// DONE     | one-cycle completion
module ild_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  StartILD,
    input  logic [15:0] PC,
    input  logic [7:0]  RegL,
    input  logic [7:0]  RegH,
    input  logic [7:0]  RegA,
    input  logic [7:0]  MemDataIn,
    input  logic        MemAck,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemDataOut,
    output logic        PC_Inc,
    output logic        WriteL,
    output logic        WriteH,
    output logic        WriteA,
    output logic [7:0]  WriteData,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        XFER0    = 3'd3,
        XFER1    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  kind_q, kind_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] nn_q, nn_d;
    logic [7:0]  l_q, l_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  a_q, a_d;

    logic start_ok;
    logic kind_wr;
    logic kind_16;

    assign start_ok = (StartILD != 4'd0) && ((StartILD & (StartILD - 4'd1)) == 4'd0);
    assign kind_wr  = kind_q[0] | kind_q[2];
    assign kind_16  = kind_q[0] | kind_q[1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            kind_q  <= 4'd0;
            pc_q    <= 16'd0;
            nn_q    <= 16'd0;
            l_q     <= 8'd0;
            h_q     <= 8'd0;
            a_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            nn_q    <= nn_d;
            l_q     <= l_d;
            h_q     <= h_d;
            a_q     <= a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pc_d    = pc_q;
        nn_d    = nn_q;
        l_d     = l_q;
        h_d     = h_q;
        a_d     = a_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = FETCH_LO;
                    kind_d  = StartILD;
                    pc_d    = PC;
                    l_d     = RegL;
                    h_d     = RegH;
                    a_d     = RegA;
                end
            end
            FETCH_LO: if (MemAck) begin
                nn_d[7:0] = MemDataIn;
                state_d   = FETCH_HI;
            end
            FETCH_HI: if (MemAck) begin
                nn_d[15:8] = MemDataIn;
                state_d    = XFER0;
            end
            XFER0:   if (MemAck) state_d = kind_16 ? XFER1 : DONE;
            XFER1:   if (MemAck) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while RESET is high so an aborted sequence
    // cannot emit a strobe in the reset cycle itself.
    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        MemAddr    = 16'd0;
        MemDataOut = 8'd0;
        PC_Inc     = 1'b0;
        WriteL     = 1'b0;
        WriteH     = 1'b0;
        WriteA     = 1'b0;
        WriteData  = 8'd0;
        Busy       = 1'b0;
        Done       = 1'b0;
        if (!RESET) begin
            Busy = (state_q != IDLE);
            case (state_q)
                FETCH_LO: begin
                    MemReq  = 1'b1;
                    MemAddr = pc_q;
                    PC_Inc  = MemAck;
                end
                FETCH_HI: begin
                    MemReq  = 1'b1;
                    MemAddr = pc_q + 16'd1;
                    PC_Inc  = MemAck;
                end
                XFER0: begin
                    MemReq  = 1'b1;
                    MemAddr = nn_q;
                    if (kind_wr) begin
                        MemWrite   = 1'b1;
                        MemDataOut = kind_q[0] ? l_q : a_q;
                    end else if (MemAck) begin
                        WriteL    = kind_q[1];
                        WriteA    = kind_q[3];
                        WriteData = MemDataIn;
                    end
                end
                XFER1: begin
                    MemReq  = 1'b1;
                    MemAddr = nn_q + 16'd1;
                    if (kind_q[0]) begin
                        MemWrite   = 1'b1;
                        MemDataOut = h_q;
                    end else if (MemAck) begin
                        WriteH    = 1'b1;
                        WriteData = MemDataIn;
                    end
                end
                DONE:    Done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ild_sequencer.md
ILD_SEQUENCER -- requirements
Module: ild_sequencer

Interface
REQ-001 CLK  in  1  single clock; all state changes on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 StartILD  in  4  one-cycle start request from the 00xxx010 decoder: [0]=lnnlHL (LD (nn),HL), [1]=HLlnnl (LD HL,(nn)), [2]=lnnlA (LD (nn),A), [3]=Alnnl (LD A,(nn)).
REQ-004 PC  in  16  program counter value, pointing at immediate byte n(lo).
REQ-005 RegL, RegH, RegA  in  8 each  register-file read values.
REQ-006 MemDataIn  in  8  memory read data, valid while MemAck=1.
REQ-007 MemAck  in  1  memory completes current access this cycle.
REQ-008 MemReq  out  1  memory access request.
REQ-009 MemWrite  out  1  1=write, 0=read; valid while MemReq=1.
REQ-010 MemAddr  out  16  access address.
REQ-011 MemDataOut  out  8  write data.
REQ-012 PC_Inc  out  1  increment PC (immediate byte consumed).
REQ-013 WriteL, WriteH, WriteA  out  1 each  register write strobes.
REQ-014 WriteData  out  8  register write data.
REQ-015 Busy  out  1  sequence in progress (state != IDLE).
REQ-016 Done  out  1  one-cycle completion pulse.

Function
REQ-017 States: IDLE, FETCH_LO, FETCH_HI, XFER0, XFER1, DONE.
REQ-018 IDLE: StartILD exactly one-hot -> capture kind, PC, RegL, RegH, RegA into holding registers; next state FETCH_LO. Zero or non-one-hot StartILD -> remain IDLE, no capture.
REQ-019 StartILD outside IDLE is ignored and does not alter the captured values.
REQ-020 FETCH_LO: MemReq=1, MemWrite=0, MemAddr=PCcap; on MemAck latch nn[7:0], PC_Inc=1 (combinational, same cycle), next FETCH_HI.
REQ-021 FETCH_HI: MemAddr=PCcap+1 (16-bit wrap, 0xFFFF->0x0000); on MemAck latch nn[15:8], PC_Inc=1, next XFER0.
REQ-022 XFER0: MemAddr=nn. Write kinds: MemWrite=1, MemDataOut = Lcap (lnnlHL) or Acap (lnnlA). Read kinds: MemWrite=0; on MemAck WriteL=1 (HLlnnl) or WriteA=1 (Alnnl), WriteData=MemDataIn, same cycle.
REQ-023 XFER0 on MemAck: 16-bit kinds (lnnlHL, HLlnnl) -> XFER1; 8-bit kinds -> DONE.
REQ-024 XFER1: MemAddr=nn+1 (16-bit wrap); lnnlHL writes Hcap; HLlnnl reads, on MemAck WriteH=1, WriteData=MemDataIn; on MemAck -> DONE.
REQ-025 Without MemAck every memory state holds, with MemReq, MemAddr, MemWrite, MemDataOut stable.
REQ-026 DONE: Done=1, MemReq=0, Busy=1 for exactly one cycle; next IDLE. A Start in DONE is ignored.
REQ-027 In IDLE and DONE: MemReq, MemWrite, PC_Inc and all Write* strobes are 0.
REQ-028 MemAddr, MemDataOut and WriteData are 0 whenever not qualified by MemReq or a write strobe.
REQ-029 At most one of WriteL/WriteH/WriteA is high in any cycle; PC_Inc and any Write* strobe are never high together.
REQ-030 Minimum latency with MemAck tied high: 8-bit kinds take 3 access cycles plus DONE (Done in cycle 4 after the Start edge); 16-bit kinds take 4 plus DONE (Done in cycle 5).

Reset
REQ-031 RESET=1 at an edge -> state IDLE; holding registers, nn, and all outputs 0, overriding any Start or MemAck in the same cycle.
REQ-032 RESET mid-sequence aborts immediately: no further PC_Inc, Write* or Done for the aborted sequence; the first Start after release is accepted normally.

Verification
REQ-033 Alnnl, PC=0x1000, MemAck=1, mem[0x1000]=0x34, mem[0x1001]=0x12, mem[0x1234]=0x5A -> reads at 0x1000, 0x1001, 0x1234; PC_Inc pulses twice; WriteA=1 with 0x5A; Done 4 cycles after Start.
REQ-034 lnnlHL, PC=0x2000, nn=0xFFFF, L=0xAB, H=0xCD -> writes 0xAB@0xFFFF, then 0xCD@0x0000; Done 5 cycles after Start.
REQ-035 HLlnnl with MemAck low for 2 cycles during each access -> outputs stable while stalled; WriteL then WriteH fire only on the ack cycles; Done after the last ack.
REQ-036 StartILD=4'b0101 in IDLE -> no transition, Busy=0; StartILD=4'b1000 during FETCH_HI -> ignored, sequence unchanged.
REQ-037 RESET asserted in XFER0 of lnnlA -> next cycle IDLE, MemReq=0, no Done; new Start accepted on the cycle after release.
REQ-038 PC=0xFFFF with lnnlA -> immediates fetched from 0xFFFF and 0x0000.
